// File: rtl/jt51_wrqueue.sv
// Host register-write queue for the jt51 bus port: buffers {addr,data} pairs and
// replays them as paced a0=0/a0=1 strobes. Optional macro: JT51_WRQ_ADDR_CACHE_EN.
module jt51_wrqueue #(
  parameter int unsigned DW_LOG2   = 4,
  parameter int unsigned BUSY_HOLD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen_p1,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [7:0]         wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               flush,
  output logic [DW_LOG2:0]   level,
  output logic               idle,
  output logic               opm_cs_n,
  output logic               opm_wr_n,
  output logic               opm_a0,
  output logic [7:0]         opm_din,
  input  logic [7:0]         opm_status
);

  localparam int unsigned        Depth    = 2 ** DW_LOG2;
  localparam logic [DW_LOG2:0]   DepthCnt = (DW_LOG2 + 1)'(Depth);
  localparam logic [DW_LOG2:0]   CntOne   = (DW_LOG2 + 1)'(1);
  localparam logic [DW_LOG2-1:0] PtrOne   = DW_LOG2'(1);
  localparam logic [7:0]         HoldN    = 8'(BUSY_HOLD);

  typedef enum logic [2:0] {StIdle, StAddr, StGap, StData, StHold, StPoll} state_e;

  state_e               state_q, state_d;
  logic [15:0]          mem_q [Depth];
  logic [DW_LOG2-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DW_LOG2:0]     cnt_q, cnt_d;
  logic [7:0]           hold_addr_q, hold_addr_d, hold_data_q, hold_data_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic                 cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d;
  logic [7:0]           din_q, din_d;
  logic                 full, empty, push, pop;
  logic [15:0]          pop_word;
  logic                 unused_status;
`ifdef JT51_WRQ_ADDR_CACHE_EN
  logic [7:0]           cache_q, cache_d;
  logic                 cache_vld_q, cache_vld_d;
`endif

  assign unused_status = ^opm_status[6:0];

  // FIFO bookkeeping; flush overrides both push and pop on the same edge.
  always_comb begin
    full     = (cnt_q == DepthCnt);
    empty    = (cnt_q == '0);
    push     = wr_valid && !full && !flush;
    pop      = (state_q == StIdle) && !empty && !flush;
    pop_word = mem_q[rptr_q];
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrOne;
      if (pop)  rptr_d = rptr_q + PtrOne;
      if (push && !pop)      cnt_d = cnt_q + CntOne;
      else if (pop && !push) cnt_d = cnt_q - CntOne;
    end
  end

  // Strobe phases advance only on a cen_p1 edge at which the registered strobe
  // state is already visible to the chip, so every phase is really sampled.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef JT51_WRQ_ADDR_CACHE_EN
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          hold_addr_d = pop_word[15:8];
          hold_data_d = pop_word[7:0];
          state_d     = StAddr;
`ifdef JT51_WRQ_ADDR_CACHE_EN
          if (cache_vld_q && cache_q == pop_word[15:8]) state_d = StData;
`endif
        end
      end
      StAddr: begin
        if (cen_p1 && !wr_n_q && !a0_q) begin
          state_d = StGap;
`ifdef JT51_WRQ_ADDR_CACHE_EN
          cache_d     = hold_addr_q;
          cache_vld_d = 1'b1;
`endif
        end
      end
      StGap: begin
        if (cen_p1 && wr_n_q) state_d = StGap == StGap ? StData : StGap;
      end
      StData: begin
        if (cen_p1 && !wr_n_q && a0_q) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        if (hold_cnt_q >= HoldN) state_d = StPoll;
        else if (cen_p1)         hold_cnt_d = hold_cnt_q + 8'd1;
      end
      StPoll: begin
        if (cen_p1 && !opm_status[7]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus pins follow the current state one clk later.
  always_comb begin
    cs_n_d = !((state_q == StAddr) || (state_q == StData));
    wr_n_d = cs_n_d;
    a0_d   = (state_q == StData);
    din_d  = din_q;
    if (state_q == StAddr)      din_d = hold_addr_q;
    else if (state_q == StData) din_d = hold_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      a0_q        <= 1'b0;
      din_q       <= '0;
`ifdef JT51_WRQ_ADDR_CACHE_EN
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      a0_q        <= a0_d;
      din_q       <= din_d;
`ifdef JT51_WRQ_ADDR_CACHE_EN
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {wr_addr, wr_data};
  end

  assign wr_ready = !full;
  assign level    = cnt_q;
  assign idle     = empty && (state_q == StIdle);
  assign opm_cs_n = cs_n_q;
  assign opm_wr_n = wr_n_q;
  assign opm_a0   = a0_q;
  assign opm_din  = din_q;

endmodule

// File: tb/tb_jt51_wrqueue.sv
// Scoreboard bench for jt51_wrqueue: accepted pairs queue their expected bus writes,
// a monitor pops and compares each wr_n falling strobe.
module tb_jt51_wrqueue;

  logic       clk = 1'b0;
  logic       rst, cen_p1, wr_valid, wr_ready, flush, idle;
  logic       opm_cs_n, opm_wr_n, opm_a0;
  logic [7:0] wr_addr, wr_data, opm_din, opm_status;
  logic [4:0] level;

  always #5 clk = ~clk;

  jt51_wrqueue #(.DW_LOG2(4), .BUSY_HOLD(2)) dut (
    .clk(clk), .rst(rst), .cen_p1(cen_p1), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .level(level), .idle(idle),
    .opm_cs_n(opm_cs_n), .opm_wr_n(opm_wr_n), .opm_a0(opm_a0), .opm_din(opm_din),
    .opm_status(opm_status)
  );

`ifdef JT51_WRQ_ADDR_CACHE_EN
  localparam int ExpAddrStrobes = 1;
`else
  localparam int ExpAddrStrobes = 2;
`endif

  int         tests = 0, fails = 0;
  int         cyc = 0, strobe_cnt = 0, addr_strobe_cnt = 0, last_strobe_cyc = 0;
  logic       last_a0 = 1'b0, prev_wr_n = 1'b1;
  logic [8:0] exp_q[$];
  logic [7:0] m_last = '0, seen_addr = '0;
  bit         m_vld = 1'b0, seen_vld = 1'b0, cen_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each pair is an address write then a data write; with the cache,
  // the address write is skipped when it repeats the previously written address.
  function automatic void model_accept(input logic [7:0] a, input logic [7:0] d);
`ifdef JT51_WRQ_ADDR_CACHE_EN
    if (!(m_vld && m_last == a)) exp_q.push_back({1'b0, a});
`else
    exp_q.push_back({1'b0, a});
`endif
    m_vld  = 1'b1;
    m_last = a;
    exp_q.push_back({1'b1, d});
  endfunction

  initial begin
    cen_p1 = 1'b0;
    forever begin
      @(negedge clk);
      cen_p1 = cen_mode ? 1'($urandom_range(0, 1)) : ~cen_p1;
    end
  end

  // Monitor: one jt51 write per wr_n falling edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      prev_wr_n = 1'b1;
    end else begin
      if (prev_wr_n && !opm_wr_n) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
        last_a0 = opm_a0;
        if (!opm_a0) begin
          addr_strobe_cnt++;
          seen_addr = opm_din;
          seen_vld  = 1'b1;
        end
        check("strobe_cs_n", 32'(opm_cs_n), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_unexpected: got write a0=%0d din=0x%0h, expected no write",
                   opm_a0, opm_din);
        end else begin
          check("bus_write", 32'({opm_a0, opm_din}), 32'(exp_q.pop_front()));
        end
      end
      prev_wr_n = opm_wr_n;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d, output bit acc);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    acc      = wr_ready;
    if (acc) model_accept(a, d);
  endtask

  task automatic release_bus();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // want: 0/1 for a specific a0, -1 for any strobe.
  task automatic wait_strobe(input string name, input int s0, input int want, input int budget);
    int n = 0;
    while (!(strobe_cnt > s0 && (want < 0 || int'(last_a0) == want)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_strobe_seen"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(idle), 32'd1);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n_acc, s0, s1, a0c, acc_cyc, c;
    rst = 1'b1; wr_valid = 1'b0; flush = 1'b0; wr_addr = '0; wr_data = '0; opm_status = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(opm_cs_n), 32'd1);
    check("rst_wr_n", 32'(opm_wr_n), 32'd1);
    check("rst_a0", 32'(opm_a0), 32'd0);
    check("rst_din", 32'(opm_din), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;

    // Single pair with latency from accept to first strobe.
    s0 = strobe_cnt;
    push(8'h20, 8'hC7, acc);
    acc_cyc = cyc + 1;
    release_bus();
    check("t1_accept", 32'(acc), 32'd1);
    wait_strobe("t1_addr", s0, 0, 20);
    check("t1_latency", 32'(last_strobe_cyc - acc_cyc), 32'd2);
    wait_idle("t1", 200);

    // Fill while the chip stays busy: 1 in flight + 16 queued, 18th refused.
    opm_status = 8'h80 | 8'($urandom_range(0, 127));
    s0 = strobe_cnt;
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      push(8'($urandom), 8'($urandom), acc);
      n_acc += int'(acc);
    end
    release_bus();
    check("t2_accepted", 32'(n_acc), 32'd17);
    check("t2_level_full", 32'(level), 32'd16);
    check("t2_ready_low", 32'(wr_ready), 32'd0);
    push(8'h11, 8'h22, acc);
    release_bus();
    check("t2_refused", 32'(acc), 32'd0);
    check("t2_level_still", 32'(level), 32'd16);

    // Busy held: no strobes for 40 clks, then quick restart after busy clears.
    wait_strobe("t3_data", s0, 1, 100);
    s1 = strobe_cnt;
    repeat (40) @(negedge clk);
    check("t3_no_strobe_busy", 32'(strobe_cnt), 32'(s1));
    check("t3_not_idle", 32'(idle), 32'd0);
    opm_status = 8'($urandom_range(0, 127));
    do @(posedge clk); while (!cen_p1);
    #2;
    c = cyc;
    wait_strobe("t3_resume", s1, -1, 20);
    check("t3_resume_latency_ok", 32'(last_strobe_cyc - c <= 3), 32'd1);
    wait_idle("t3", 3000);
    check("t3_level_drained", 32'(level), 32'd0);

    // Flush during the first pair's data write; a same-edge push is dropped.
    opm_status = 8'h80;
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 8'($urandom), acc);
    release_bus();
    wait_strobe("t4_data", s0, 1, 100);
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 8'h55;
    wr_data = 8'h66;
    exp_q.delete();
    m_vld = seen_vld;
    m_last = seen_addr;
    @(negedge clk);
    flush = 1'b0;
    wr_valid = 1'b0;
    check("t4_level_flushed", 32'(level), 32'd0);
    check("t4_ready", 32'(wr_ready), 32'd1);
    s1 = strobe_cnt;
    opm_status = 8'h00;
    wait_idle("t4", 300);
    check("t4_no_more_strobes", 32'(strobe_cnt), 32'(s1));

    // Reset while an address strobe is on the bus.
    s0 = strobe_cnt;
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i), 8'($urandom), acc);
    release_bus();
    wait_strobe("t5_addr", s0, 0, 50);
    rst = 1'b1;
    exp_q.delete();
    m_vld = 1'b0;
    seen_vld = 1'b0;
    @(negedge clk);
    check("t5_cs_n", 32'(opm_cs_n), 32'd1);
    check("t5_wr_n", 32'(opm_wr_n), 32'd1);
    check("t5_level", 32'(level), 32'd0);
    rst = 1'b0;
    s1 = strobe_cnt;
    repeat (30) @(negedge clk);
    check("t5_no_partial", 32'(strobe_cnt), 32'(s1));

    // Repeated address: address write skipped only with the cache.
    s0 = strobe_cnt;
    a0c = addr_strobe_cnt;
    push(8'h08, 8'h01, acc);
    push(8'h08, 8'h02, acc);
    release_bus();
    wait_idle("t6", 300);
    check("t6_addr_strobes", 32'(addr_strobe_cnt - a0c), 32'(ExpAddrStrobes));
    check("t6_total_strobes", 32'(strobe_cnt - s0), 32'(ExpAddrStrobes + 2));

    // Random traffic with random cen_p1 and busy.
    cen_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      opm_status = {1'($urandom_range(0, 3) == 0), 7'($urandom)};
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr = 8'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      if (wr_valid && wr_ready) model_accept(wr_addr, wr_data);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    opm_status = 8'h00;
    wait_idle("rand", 6000);
    check("rand_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
